// File: rtl/somador_subtrator_seq.sv
// Sequential adder/subtractor: K bits per cycle, LSB first, over N/K cycles.
// Optional saturation and an accumulator that can replace operand a.
module somador_subtrator_seq #(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         limpa,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         select,
  input  logic         acumula,
  input  logic         satura,
  output logic [N:0]   resul,
  output logic         pronto,
  output logic         ocupado,
  output logic         overflow,
  output logic         zero
);
  localparam int STEPS = N / K;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {OCIOSO, CALCULA, PRONTO} estado_t;
  typedef struct packed {
    logic sub;
    logic sat;
  } modo_t;

  estado_t       estado, prox;
  modo_t         modo;
  logic [N-1:0]  opa, opb, soma, soma_nx, acc;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [K-1:0]  fa, fb, fs;
  logic          fc, ultimo, msb;
  logic [N:0]    res_fim;

  // One K-bit slice; subtraction is a + ~b with the carry seeded to 1.
  assign fa = opa[K-1:0];
  assign fb = modo.sub ? ~opb[K-1:0] : opb[K-1:0];
  assign {fc, fs} = {1'b0, fa} + {1'b0, fb} + {{K{1'b0}}, carry};

  generate
    if (K == N) begin : g_um
      assign soma_nx = fs;
    end else begin : g_desl
      assign soma_nx = {fs, soma[N-1:K]};
    end
  endgenerate

  assign ultimo = (cnt == LAST);
  // Bit N is the carry for add, the borrow (inverted carry) for sub.
  assign msb = modo.sub ? ~fc : fc;

  always_comb begin
    res_fim = {msb, soma_nx};
    if (modo.sat && msb)
      res_fim = modo.sub ? '0 : {1'b0, {N{1'b1}}};
  end

  always_ff @(posedge clock) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:  if (iniciar && !limpa) prox = CALCULA;
      CALCULA: if (ultimo) prox = PRONTO;
      PRONTO:  prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      resul    <= '0;
      overflow <= 1'b0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      opa      <= '0;
      opb      <= '0;
      soma     <= '0;
      modo     <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (limpa) begin
            acc <= '0;
          end else if (iniciar) begin
            opa   <= acumula ? acc : a;
            opb   <= b;
            modo  <= '{sub: select, sat: satura};
            carry <= select;
            cnt   <= '0;
          end
        end
        CALCULA: begin
          opa   <= opa >> K;
          opb   <= opb >> K;
          soma  <= soma_nx;
          carry <= fc;
          cnt   <= cnt + CW'(1);
          // Results land on the edge that enters PRONTO.
          if (ultimo) begin
            resul    <= res_fim;
            overflow <= msb;
            acc      <= res_fim[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign pronto  = (estado == PRONTO);
  assign ocupado = (estado != OCIOSO);
  assign zero    = (resul == '0);

endmodule

// File: doc/somador_subtrator_seq.md
SOMADOR_SUBTRATOR_SEQ -- requirements
Module: somador_subtrator_seq

Interface
REQ-001 Parameter N, default 8: operand width in bits; N >= 2.
REQ-002 Parameter K, default 2: bits processed per CALCULA cycle; N SHALL be an integer multiple of K.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset; synchronous and active-low.
REQ-005 iniciar  input  1  start request; sampled only in OCIOSO.
REQ-006 limpa  input  1  clears accumulator; sampled only in OCIOSO.
REQ-007 a  input  N  operand A, unsigned.
REQ-008 b  input  N  operand B, unsigned.
REQ-009 select  input  1  operation: 0 = a+b, 1 = a-b.
REQ-010 acumula  input  1  1 = accumulator replaces operand a.
REQ-011 satura  input  1  1 = saturating result.
REQ-012 resul  output  N+1  registered result.
REQ-013 pronto  output  1  one-cycle completion pulse.
REQ-014 ocupado  output  1  high whenever state is not OCIOSO.
REQ-015 overflow  output  1  unsigned carry (add) or borrow (sub) of last operation.
REQ-016 zero  output  1  resul == 0.

Function
REQ-017 FSM states: OCIOSO, CALCULA, PRONTO; the block SHALL have no other reachable state.
REQ-018 OCIOSO with limpa=1: accumulator SHALL clear to 0; iniciar in the same cycle SHALL be ignored.
REQ-019 OCIOSO with iniciar=1 and limpa=0: a (or accumulator if acumula=1), b, select and satura SHALL be captured, and the next state SHALL be CALCULA.
REQ-020 CALCULA: the block SHALL process K bits per cycle, LSB first, with carry/borrow chained between slices, for exactly N/K cycles, then go to PRONTO.
REQ-021 PRONTO: resul, overflow and zero SHALL be updated on entry; pronto=1 for exactly one cycle; next state OCIOSO.
REQ-022 Latency: the capture edge is followed by N/K CALCULA cycles plus 1 PRONTO cycle; pronto SHALL assert N/K+1 cycles after the capture edge.
REQ-023 iniciar, limpa and operand changes while ocupado=1 SHALL be ignored; captured operands SHALL be used.
REQ-024 Add (satura=0): resul = zero-extended a+b over N+1 bits; overflow = resul[N].
REQ-025 Sub (satura=0): resul = (a-b) mod 2^(N+1); overflow = 1 if a<b (equivalently resul[N]).
REQ-026 satura=1 and overflow: add SHALL give resul = {0, N ones}; sub SHALL give resul = 0; overflow SHALL still be 1.
REQ-027 Accumulator SHALL load resul[N-1:0] (after saturation) in PRONTO, whether or not acumula=1.
REQ-028 resul, overflow and zero SHALL hold between operations until the next PRONTO.
REQ-029 K=N SHALL yield exactly 1 CALCULA cycle.

Reset
REQ-030 With reset=0 at a rising edge, state SHALL become OCIOSO, and resul, accumulator, internal carry and slice counter SHALL become 0.
REQ-031 After reset, outputs SHALL be: pronto=0, ocupado=0, overflow=0, zero=1.
REQ-032 Reset in CALCULA or PRONTO SHALL abort the operation; no pronto pulse SHALL follow for that operation.
REQ-033 Reset SHALL take priority over iniciar and limpa.

Verification (N=8, K=2)
REQ-034 Add, a=200, b=100, satura=0 -> pronto 5 cycles after capture, resul=9'h12C, overflow=1, zero=0; repeat with satura=1 -> resul=9'h0FF, overflow=1.
REQ-035 Sub, a=5, b=7 -> resul=9'h1FE, overflow=1; with satura=1 -> resul=0, zero=1; a=7, b=7 -> resul=0, overflow=0, zero=1.
REQ-036 limpa, then three operations add, acumula=1, b=10 -> resul 10, 20, 30; then limpa with iniciar in the same cycle -> no operation starts, and the next acumula add b=1 -> resul=1.
REQ-037 iniciar asserted during CALCULA with different operands -> ignored; exactly one pronto for the first operation, with the first operation's result.
REQ-038 reset=0 during the 2nd CALCULA cycle -> the next cycle has ocupado=0, resul=0, zero=1, and no pronto; a fresh add 3+4 -> resul=7.
REQ-039 K=8: add 1+1 -> pronto 2 cycles after capture, resul=2.
